// File: rtl/mod_mul_serial_if.sv
// Request/response bundle for the bit-serial secp256k1 field multiplier.
// Handshake: start is a request that is taken only while busy is low; done pulses for one cycle with product valid.
interface mod_mul_serial_if #(
    parameter int WIDTH = 256
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier, product = (a * b) mod P, one multiplier bit per clock, MSB first.
// Optional MOD_MUL_ZERO_BYPASS_EN: a zero operand skips the RUN phase and finishes the cycle after the start edge.
module mod_mul_serial (
    input  logic                 clk,
    input  logic                 reset,
    mod_mul_serial_if.slave      bus,
    output logic [1:0]           state_dbg
);
    localparam int WIDTH = 256;
    localparam logic [WIDTH-1:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] product_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] dbl;
    logic [WIDTH-1:0] nxt;
    logic             zero_bypass;

    // Both inputs are < P, so a single conditional subtract fully reduces the sum.
    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, P}) begin
            s = s - {1'b0, P};
        end
        return s[WIDTH-1:0];
    endfunction

    always_comb begin
        dbl = mod_add(acc, acc);
        nxt = dbl;
        if (b_sh[WIDTH-1]) begin
            nxt = mod_add(dbl, a_r);
        end
    end

`ifdef MOD_MUL_ZERO_BYPASS_EN
    assign zero_bypass = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            a_r       <= '0;
            b_sh      <= '0;
            acc       <= '0;
            cnt       <= '0;
            product_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if (zero_bypass) begin
                            product_r <= '0;
                            done_r    <= 1'b1;
                            state     <= DONE;
                        end else begin
                            a_r   <= bus.a;
                            b_sh  <= bus.b;
                            acc   <= '0;
                            cnt   <= 8'd255;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc  <= nxt;
                    b_sh <= b_sh << 1;
                    cnt  <= cnt - 8'd1;
                    // cnt==0 marks the last multiplier bit; its result is the product.
                    if (cnt == 8'd0) begin
                        product_r <= nxt;
                        done_r    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = product_r;
    assign state_dbg   = state;
endmodule

// File: tb/tb_mod_mul_serial.sv
// Directed bench for mod_mul_serial: vector table plus reset-abort, mid-run start and back-to-back sequences.
module tb_mod_mul_serial;
    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam int BUDGET = 400;

    typedef struct {
        string        name;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         vec_cnt;
    int         err_cnt;
    vec_t       vecs[9];

    mod_mul_serial_if bus ();

    mod_mul_serial dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts one job, optionally pulses start again glitch_at edges in, and checks latency and result.
    task automatic run_job(input string nm, input logic [255:0] av, input logic [255:0] bv,
                           input logic [255:0] expv, input int glitch_at);
        int n;
        int exp_lat;
        exp_lat = 256;
`ifdef MOD_MUL_ZERO_BYPASS_EN
        if (av == '0 || bv == '0) exp_lat = 0;
`endif
        @(negedge clk);
        bus.a = av;
        bus.b = bv;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk({nm, "_busy"}, 256'(bus.busy), 256'd1);
        n = 0;
        while (!bus.done && n < BUDGET) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == glitch_at) begin
                bus.start = 1'b1;
                bus.a = 256'd1;
                bus.b = 256'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk({nm, "_latency"}, 256'(n), 256'(exp_lat));
        chk({nm, "_product"}, bus.product, expv);
        @(negedge clk);
        chk({nm, "_done_width"}, 256'(bus.done), 256'd0);
        chk({nm, "_idle"}, 256'(bus.busy), 256'd0);
        chk({nm, "_held"}, bus.product, expv);
    endtask

    initial begin
        int n;
        int done_seen;
        vec_cnt = 0;
        err_cnt = 0;

        vecs[0] = '{"3x5",        256'd3,         256'd5,         256'd15};
        vecs[1] = '{"pm1xpm1",    P - 256'd1,     P - 256'd1,     256'd1};
        vecs[2] = '{"pm1x2",      P - 256'd1,     256'd2,         P - 256'd2};
        vecs[3] = '{"2p255x2",    256'd1 << 255,  256'd2,         256'h1_000003D1};
        vecs[4] = '{"2p128sq",    256'd1 << 128,  256'd1 << 128,  256'h1_000003D1};
        vecs[5] = '{"1xpm1",      256'd1,         P - 256'd1,     P - 256'd1};
        vecs[6] = '{"small",      256'h12345,     256'h10000,     256'h1_2345_0000};
        vecs[7] = '{"0x5",        256'd0,         256'd5,         256'd0};
        vecs[8] = '{"7x6",        256'd7,         256'd6,         256'd42};

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_done", 256'(bus.done), 256'd0);
        chk("rst_product", bus.product, 256'd0);
        chk("rst_state", 256'(state_dbg), 256'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_job(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp, 0);
        end

        // Start held high: the next job is accepted on the second edge after done.
        @(negedge clk);
        bus.a = 256'd3;
        bus.b = 256'd5;
        bus.start = 1'b1;
        n = 0;
        while (!bus.done && n < BUDGET) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("b2b_first_done", 256'(bus.done), 256'd1);
        @(negedge clk);
        chk("b2b_gap_idle", 256'(bus.busy), 256'd0);
        @(negedge clk);
        chk("b2b_reaccept", 256'(bus.busy), 256'd1);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < BUDGET) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("b2b_second_product", bus.product, 256'd15);
        @(negedge clk);

        // Reset in the middle of a job discards it.
        bus.a = 256'd9;
        bus.b = 256'd9;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 256'(bus.busy), 256'd0);
        chk("abort_done", 256'(bus.done), 256'd0);
        chk("abort_product", bus.product, 256'd0);
        chk("abort_state", 256'(state_dbg), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("abort_no_done", 256'(done_seen), 256'd0);

        run_job("7x6_glitch", 256'd7, 256'd6, 256'd42, 50);
        run_job("0x5_again", 256'd0, 256'd5, 256'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
